// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS register-file widths and named register constants
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_rdport.sv
// rtl/reg_file_rdport.sv - combinational register read mux with $0 force and optional write bypass
module reg_file_rdport
    import mips_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] regs [1 << ADDR_W],
    output logic [DATA_W-1:0] rd
);

    // Address 0 always reads zero; wr_en already excludes wa==0 and reset.
    always_comb begin
        rd = '0;
        if (ra != '0) begin
            if ((BYPASS != 0) && wr_en && (ra == wa)) begin
                rd = wd;
            end else begin
                rd = regs[ra];
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 MIPS register file, two async read ports, one sync write port
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_en;

    // Reset outranks write; $0 is never a write target.
    assign wr_en = we && !rst && (wa != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    reg_file_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rdport1 (
        .ra    (ra1),
        .wa    (wa),
        .wd    (wd),
        .wr_en (wr_en),
        .regs  (regs),
        .rd    (rd1)
    );

    reg_file_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rdport2 (
        .ra    (ra2),
        .wa    (wa),
        .wd    (wd),
        .wr_en (wr_en),
        .regs  (regs),
        .rd    (rd2)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file, read-first and write-first builds side by side
module tb_reg_file;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd1_rf, rd2_rf, rd1_wf, rd2_wf;

    int checks;
    int errors;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [32];

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_rf (
        .clk (clk), .rst (rst), .ra1 (ra1), .ra2 (ra2), .wa (wa),
        .wd  (wd),  .we  (we),  .rd1 (rd1_rf), .rd2 (rd2_rf)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_wf (
        .clk (clk), .rst (rst), .ra1 (ra1), .ra2 (ra2), .wa (wa),
        .wd  (wd),  .we  (we),  .rd1 (rd1_wf), .rd2 (rd2_wf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observed(input int sel);
        case (sel)
            0:       return rd1_rf;
            1:       return rd2_rf;
            2:       return rd1_wf;
            default: return rd2_wf;
        endcase
    endfunction

    function automatic string port_name(input int sel);
        case (sel)
            0:       return "rf.rd1";
            1:       return "rf.rd2";
            2:       return "wf.rd1";
            default: return "wf.rd2";
        endcase
    endfunction

    // Expected values for both ports of both builds; compared after outputs settle.
    task automatic expect_rd(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] e1_rf, input logic [31:0] e2_rf,
                             input logic [31:0] e1_wf, input logic [31:0] e2_wf);
        exp_t e;
        ra1 = a1;
        ra2 = a2;
        e.tag = tag; e.sel = 0; e.exp = e1_rf; sb.push_back(e);
        e.sel = 1; e.exp = e2_rf; sb.push_back(e);
        e.sel = 2; e.exp = e1_wf; sb.push_back(e);
        e.sel = 3; e.exp = e2_wf; sb.push_back(e);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".", port_name(e.sel)}, observed(e.sel), e.exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = 1'b0; we = 1'b1; wa = a; wd = d;
        @(negedge clk);
        we = 1'b0;
        if (a != 5'd0) mdl[a] = d;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    function automatic logic [31:0] mdl_read(input logic [4:0] a, input bit bypass);
        if (a == 5'd0) return 32'h0;
        if (bypass && we && !rst && (wa == a)) return wd;
        return mdl[a];
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        expect_rd("por_zero", 5'd4, 5'd17, 32'h0, 32'h0, 32'h0, 32'h0);

        // 1: fill with ones, then reset clears everything
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hFFFF_FFFF);
        expect_rd("fill_ones", 5'd5, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        pulse_reset();
        for (int i = 0; i < 32; i++) begin
            expect_rd($sformatf("reset_a%0d", i), 5'(i), 5'(31 - i), 32'h0, 32'h0, 32'h0, 32'h0);
        end

        // 2: basic write/read, both ports on the same register
        write_reg(5'd9, 32'hDEAD_BEEF);
        expect_rd("wr9", 5'd9, 5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // 3: $0 cannot be written or bypassed
        @(negedge clk);
        we = 1'b1; wa = 5'd0; wd = 32'h1234_5678;
        expect_rd("zero_pre", 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        we = 1'b0;
        expect_rd("zero_post", 5'd0, 5'd9, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);

        // 4: read during write to the same address
        write_reg(5'd3, 32'hA);
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 32'hB;
        expect_rd("rdw_pre", 5'd3, 5'd9, 32'hA, 32'hDEAD_BEEF, 32'hB, 32'hDEAD_BEEF);
        @(negedge clk);
        we = 1'b0; mdl[3] = 32'hB;
        expect_rd("rdw_post", 5'd3, 5'd3, 32'hB, 32'hB, 32'hB, 32'hB);

        // 5: reset beats write on the same edge, and blocks bypass before it
        write_reg(5'd7, 32'h99);
        @(negedge clk);
        rst = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'h55;
        expect_rd("rstwr_pre", 5'd7, 5'd3, 32'h99, 32'hB, 32'h99, 32'hB);
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        expect_rd("rstwr_post", 5'd7, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0);

        // 6: dual port, swapped addresses
        write_reg(5'd1, 32'h1);
        write_reg(5'd31, 32'h8000_0000);
        expect_rd("dual", 5'd1, 5'd31, 32'h1, 32'h8000_0000, 32'h1, 32'h8000_0000);
        expect_rd("dual_swap", 5'd31, 5'd1, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'h1);

        write_reg(REG_SP, 32'h7FFF_EFFC);
        write_reg(REG_RA, 32'h0040_0018);
        expect_rd("sp_ra", REG_SP, REG_RA, 32'h7FFF_EFFC, 32'h0040_0018, 32'h7FFF_EFFC, 32'h0040_0018);

        // Random traffic against the reference array
        for (int n = 0; n < 300; n++) begin
            logic [4:0] a1, a2;
            @(negedge clk);
            rst = 1'b0;
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            a1  = (n % 4 == 0) ? wa : 5'($urandom_range(0, 31));
            a2  = 5'($urandom_range(0, 31));
            ra1 = a1;
            ra2 = a2;
            expect_rd($sformatf("rnd%0d", n), a1, a2,
                      mdl_read(a1, 1'b0), mdl_read(a2, 1'b0),
                      mdl_read(a1, 1'b1), mdl_read(a2, 1'b1));
            if (we && wa != 5'd0) mdl[wa] = wd;
        end
        @(negedge clk);
        we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
